y86_fetch_queue: RTL and testbench
==================================

Name: y86_fetch_queue

Overview:
- Parametrised, pipelined successor to the SEQ fetch stage.
- Pulls instruction bytes from memory as aligned BUS_BYTES-wide words into a byte queue.
- Assembles variable-length Y86 instructions (1/2/9/10 bytes) and emits one decoded instruction per cycle over a valid/ready handshake.
- Supports PC redirect with flush; sits between instruction memory and decode.

Parameters:
- BUS_BYTES, 8, memory read width in bytes (power of 2, 2..16).
- QDEPTH, 32, byte queue capacity (power of 2, >= 10 + 2*BUS_BYTES).
- MEM_BYTES, 1024, instruction memory size; addresses >= MEM_BYTES are errors.
- RESET_PC, 0, PC fetched after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch PC.
- mem_req_valid  out  1  read request.
- mem_req_addr  out  64  BUS_BYTES-aligned read address.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  read data returned; at most one request is outstanding.
- mem_resp_data  in  8*BUS_BYTES  byte k = bits [8k+7:8k] = address addr+k.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  decode accepts.
- pc  out  64  address of the instruction.
- icode, ifun, rA, rB  out  4 each  decoded fields.
- valC  out  64  constant.
- valP  out  64  pc + length.
- instr_valid  out  1  0 for an illegal icode.
- imem_error  out  1  instruction touches an address >= MEM_BYTES.
- hlt  out  1  icode == 0.

Behaviour:
- Reset (async): queue empty, fetch PC = RESET_PC, state FETCH. Outputs out_valid=0, mem_req_valid=0, all data outputs 0, rA=rB=4'hF. mem_req_valid first asserts the cycle after reset deasserts.
- Lengths by icode:
  - 0, 1, 9 -> 1.
  - 2, 6, A, B -> 2.
  - 3, 4, 5 -> 10.
  - 7, 8 -> 9.
  - Others -> 1 with instr_valid=0.
- Field decode:
  - ifun = byte0[3:0]. rA = byte1[7:4], rB = byte1[3:0] for 2/10-byte forms; otherwise 4'hF.
  - valC is little-endian: bytes 2..9 for 10-byte forms, bytes 1..8 for 9-byte forms; otherwise 0.
  - valP = pc + length, 64-bit wrap.
- State FETCH:
  - Issues mem_req at the aligned fetch word when queue free space >= BUS_BYTES and the word address < MEM_BYTES.
  - On mem_req_valid && mem_req_ready -> WAIT.
- State WAIT:
  - On mem_resp_valid, push bytes to the queue.
  - On the first word after a redirect, drop the leading (pc mod BUS_BYTES) bytes.
  - Advance the word address by BUS_BYTES, then return to FETCH.
  - Response and request may not overlap.
- Emission:
  - out_valid=1 when queue count >= length of the head instruction; outputs are combinational from queue head.
  - Must hold stable while out_valid && !out_ready.
  - Handshake pops length bytes and sets pc <= valP.
  - Push and pop in the same cycle are both honoured.
- hlt or instr_valid=0:
  - Record is emitted normally.
  - After its handshake, state moves to HALT (no requests, out_valid=0) until redirect.
- imem_error:
  - Raised if pc >= MEM_BYTES or pc + length > MEM_BYTES.
  - Record is emitted with available fields, valP = pc, imem_error=1; after its handshake, state moves to HALT.
  - No request is ever issued to addresses >= MEM_BYTES.
- Redirect (highest priority):
  - Queue flushed; fetch PC = redirect_pc; state FETCH next cycle; out_valid=0 the cycle after.
  - An output handshake in the same cycle still completes.
  - If a request is outstanding, state moves to DISCARD; the next mem_resp_valid is dropped, then FETCH.
  - A response arriving in the redirect cycle is dropped.
  - Redirect during DISCARD updates the PC and remains in DISCARD.
- Queue full: no request issued; never overflows.
- Queue empty or partial instruction: out_valid=0; no bubbles inserted.

Optional Feature:
- Macro: Y86_FETCH_PREDICT_EN.
- Enabled: after handshake of jmp (icode 7, ifun 0) or call (icode 8), the unit self-redirects to valC exactly as an external redirect, skipping fall-through bytes. Conditional jumps continue sequentially. External redirect in the same cycle wins.
- Disabled: fetch is always sequential; only redirect_valid changes the PC.

Test Plan:
- Sequential fetch, BUS_BYTES=8, memory at 0: 30 F3 0A00000000000000 (irmovq), 60 32, 10, 00.
  - Expect: pc 0 icode3 rA F rB 3 valC 10 valP 10; pc 10 icode6 rA3 rB2 valP 12; pc 12 nop; pc 13 hlt.
  - Then no further mem_req.
- Unaligned redirect to 0x0D with call 80 2000000000000000 there.
  - Expect: request addr 0x08, first 5 bytes dropped, valC 0x20, valP 0x16.
  - With Y86_FETCH_PREDICT_EN: next pc 0x20.
- Backpressure: out_ready=0 for 20 cycles with a stream of nops.
  - Outputs stable, queue fills to QDEPTH, mem_req_valid=0; on release, one nop per cycle.
- Redirect while request outstanding: redirect to 0x40, then mem_resp_valid for the old word.
  - Response discarded; first emitted pc 0x40.
- Boundary: irmovq at 1020 with MEM_BYTES=1024.
  - Expect one record imem_error=1, pc 1020, valP 1020; then HALT, no request >= 1024.
- Byte 0xF0 at 0.
  - Expect instr_valid=0, valP 1, HALT; assert reset mid-WAIT, and all outputs return to reset values immediately.

Source files
------------

// File: rtl/y86_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : y86_fetch_queue
// Purpose  : Pipelined Y86 fetch unit. Reads aligned BUS_BYTES words into a
//            circular byte queue, assembles 1/2/9/10-byte instructions and
//            emits one decoded record per cycle over valid/ready.
//            Optional macro Y86_FETCH_PREDICT_EN: self-redirect to valC after
//            an unconditional jmp or a call.
// Revision : 1.0 - initial release
// ============================================================================
module y86_fetch_queue #(
  parameter int          BUS_BYTES = 8,
  parameter int          QDEPTH    = 32,
  parameter int          MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   mem_req_valid,
  output logic [63:0]            mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [8*BUS_BYTES-1:0] mem_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            pc,
  output logic [3:0]             icode,
  output logic [3:0]             ifun,
  output logic [3:0]             rA,
  output logic [3:0]             rB,
  output logic [63:0]            valC,
  output logic [63:0]            valP,
  output logic                   instr_valid,
  output logic                   imem_error,
  output logic                   hlt
);
  localparam int          AW        = $clog2(QDEPTH);
  localparam int          CW        = $clog2(QDEPTH + 1);
  localparam int          BW        = $clog2(BUS_BYTES);
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_run;         // low for the first cycle after reset
  logic            r_stop;        // halting record accepted, draining to HALT
  logic [7:0]      r_q [QDEPTH];
  logic [AW-1:0]   r_head;
  logic [CW-1:0]   r_count;
  logic [63:0]     r_pc;
  logic [63:0]     r_fetch_addr;
  logic [BW-1:0]   r_drop;        // leading bytes to skip in the next word

  logic [7:0]      w_b [10];
  logic [3:0]      w_icode;
  logic [3:0]      w_len;
  logic            w_iv, w_regs, w_c_at1, w_c_at2;
  logic [63:0]     w_valc, w_valp;
  logic [64:0]     w_end;
  logic            w_imem_err, w_exhausted, w_out_valid, w_hs, w_halt_hs;
  logic            w_pred, w_redir, w_req_fire, w_resp_take, w_outstanding;
  logic [63:0]     w_redir_pc;
  logic [CW-1:0]   w_free, w_push_n, w_pop_n;
  logic [AW-1:0]   w_base;

  // Peek the first ten queued bytes; bytes not yet present read as zero
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      w_b[k] = (CW'(k) < r_count) ? r_q[r_head + AW'(k)] : 8'h00;
    end
  end

  // Decode length and field layout from the head opcode byte
  always_comb begin
    w_icode = w_b[0][7:4];
    w_len   = 4'd1;
    w_iv    = 1'b1;
    w_regs  = 1'b0;
    w_c_at1 = 1'b0;
    w_c_at2 = 1'b0;
    case (w_icode)
      4'h0, 4'h1, 4'h9:       w_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin w_len = 4'd2;  w_regs = 1'b1; end
      4'h3, 4'h4, 4'h5:       begin w_len = 4'd10; w_regs = 1'b1; w_c_at2 = 1'b1; end
      4'h7, 4'h8:             begin w_len = 4'd9;  w_c_at1 = 1'b1; end
      default:                w_iv = 1'b0;
    endcase
  end

  assign w_valc = w_c_at2 ? {w_b[9], w_b[8], w_b[7], w_b[6], w_b[5], w_b[4], w_b[3], w_b[2]} :
                  w_c_at1 ? {w_b[8], w_b[7], w_b[6], w_b[5], w_b[4], w_b[3], w_b[2], w_b[1]} :
                            64'd0;
  assign w_end       = {1'b0, r_pc} + 65'(w_len);
  assign w_imem_err  = (r_pc >= MEM_LIMIT) || (w_end > {1'b0, MEM_LIMIT});
  assign w_valp      = w_imem_err ? r_pc : w_end[63:0];

  // Fetch has reached the end of memory: whatever is queued is all there is
  assign w_exhausted = (r_state == S_FETCH) && (r_fetch_addr >= MEM_LIMIT);
  assign w_out_valid = r_run && !r_stop && (r_state != S_HALT) &&
                       ((r_count >= CW'(w_len)) || w_exhausted);
  assign w_hs        = w_out_valid && out_ready;
  assign w_halt_hs   = w_hs && ((w_icode == 4'h0) || !w_iv || w_imem_err);

`ifdef Y86_FETCH_PREDICT_EN
  assign w_pred = w_hs && !w_imem_err &&
                  (((w_icode == 4'h7) && (w_b[0][3:0] == 4'h0)) || (w_icode == 4'h8));
`else
  assign w_pred = 1'b0;
`endif

  assign w_redir     = redirect_valid || w_pred;
  assign w_redir_pc  = redirect_valid ? redirect_pc : w_valc;

  assign w_free        = CW'(QDEPTH) - r_count;
  assign mem_req_valid = r_run && !r_stop && (r_state == S_FETCH) &&
                         (w_free >= CW'(BUS_BYTES)) && (r_fetch_addr < MEM_LIMIT);
  assign mem_req_addr  = mem_req_valid ? r_fetch_addr : 64'd0;
  assign w_req_fire    = mem_req_valid && mem_req_ready;
  assign w_resp_take   = (r_state == S_WAIT) && mem_resp_valid && !w_redir && !w_halt_hs;
  assign w_outstanding = (((r_state == S_WAIT) || (r_state == S_DISCARD)) && !mem_resp_valid) ||
                         w_req_fire;

  assign w_push_n = CW'(BUS_BYTES) - CW'(r_drop);
  assign w_pop_n  = !w_hs ? '0 : ((r_count >= CW'(w_len)) ? CW'(w_len) : r_count);
  assign w_base   = r_head + AW'(r_count) - AW'(r_drop);

  // Byte storage: write the kept bytes of a returned word at the queue tail
  always_ff @(posedge clk) begin
    if (w_resp_take) begin
      for (int k = 0; k < BUS_BYTES; k++) begin
        if (BW'(k) >= r_drop) r_q[w_base + AW'(k)] <= mem_resp_data[8*k +: 8];
      end
    end
  end

  // Fetch FSM, queue pointers and program counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_run        <= 1'b0;
      r_stop       <= 1'b0;
      r_head       <= '0;
      r_count      <= '0;
      r_pc         <= RESET_PC;
      r_fetch_addr <= {RESET_PC[63:BW], {BW{1'b0}}};
      r_drop       <= RESET_PC[BW-1:0];
    end else begin
      r_run  <= 1'b1;
      r_head <= r_head + AW'(w_pop_n);
      if (w_redir) begin
        r_count      <= '0;
        r_pc         <= w_redir_pc;
        r_fetch_addr <= {w_redir_pc[63:BW], {BW{1'b0}}};
        r_drop       <= w_redir_pc[BW-1:0];
        r_stop       <= 1'b0;
        r_state      <= w_outstanding ? S_DISCARD : S_FETCH;
      end else begin
        r_count <= r_count + (w_resp_take ? w_push_n : '0) - w_pop_n;
        if (w_hs) r_pc <= w_valp;
        if (w_resp_take) begin
          r_fetch_addr <= r_fetch_addr + 64'(BUS_BYTES);
          r_drop       <= '0;
        end
        if (w_halt_hs) begin
          r_stop  <= 1'b1;
          r_state <= w_outstanding ? S_DISCARD : S_HALT;
        end else begin
          case (r_state)
            S_FETCH:   if (w_req_fire) r_state <= S_WAIT;
            S_WAIT:    if (mem_resp_valid) r_state <= S_FETCH;
            S_DISCARD: if (mem_resp_valid) r_state <= r_stop ? S_HALT : S_FETCH;
            default:   r_state <= S_HALT;
          endcase
        end
      end
    end
  end

  // Record outputs are forced to their idle values whenever no record is offered
  always_comb begin
    out_valid   = w_out_valid;
    pc          = 64'd0;
    icode       = 4'h0;
    ifun        = 4'h0;
    rA          = 4'hF;
    rB          = 4'hF;
    valC        = 64'd0;
    valP        = 64'd0;
    instr_valid = 1'b0;
    imem_error  = 1'b0;
    hlt         = 1'b0;
    if (w_out_valid) begin
      pc          = r_pc;
      icode       = w_icode;
      ifun        = w_b[0][3:0];
      rA          = w_regs ? w_b[1][7:4] : 4'hF;
      rB          = w_regs ? w_b[1][3:0] : 4'hF;
      valC        = w_valc;
      valP        = w_valp;
      instr_valid = w_iv;
      imem_error  = w_imem_err;
      hlt         = (w_icode == 4'h0);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_y86_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_fetch_queue
// Purpose  : Directed self-checking bench for y86_fetch_queue with a byte
//            memory model that answers one outstanding read at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y86_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pc;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_valid, imem_error, hlt;

  y86_fetch_queue dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .instr_valid(instr_valid),
    .imem_error(imem_error), .hlt(hlt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] c, p;
    logic        iv, err, h;
    int          cyc;
  } rec_t;

  logic [7:0]  mem [1024];
  logic        hold_resp;
  logic        pend;
  logic [63:0] paddr;
  logic [63:0] req_log [$];
  rec_t        recs [$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Memory model: answer an accepted request on a later falling edge
  always @(negedge clk) begin
    if (reset) begin
      pend           = 1'b0;
      mem_resp_valid = 1'b0;
    end else begin
      mem_resp_valid = 1'b0;
      if (pend && !hold_resp) begin
        for (int k = 0; k < 8; k++) begin
          logic [9:0] a;
          a = paddr[9:0] + 10'(k);
          mem_resp_data[8*k +: 8] = mem[a];
        end
        mem_resp_valid = 1'b1;
        pend           = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        pend  = 1'b1;
        paddr = mem_req_addr;
        req_log.push_back(mem_req_addr);
      end
    end
  end

  // Record every handshake that will complete on the coming rising edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      rec_t r;
      r.pc = pc; r.ic = icode; r.fn = ifun; r.ra = rA; r.rb = rB;
      r.c = valC; r.p = valP; r.iv = instr_valid; r.err = imem_error; r.h = hlt;
      r.cyc = cyc;
      recs.push_back(r);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_redirect(input logic [63:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_recs(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (recs.size() < n && i < budget) begin step(1); i++; end
    chk(tag, 64'(recs.size() >= n), 64'd1);
  endtask

  task automatic chk_rec(input string tag, input int idx, input logic [63:0] e_pc,
                         input logic [3:0] e_ic, input logic [3:0] e_fn,
                         input logic [3:0] e_ra, input logic [3:0] e_rb,
                         input logic [63:0] e_c, input logic [63:0] e_p,
                         input logic e_iv, input logic e_err, input logic e_h);
    rec_t r;
    r = '{default: '0};
    if (idx < recs.size()) r = recs[idx];
    chk({tag, ".pc"}, r.pc, e_pc);
    chk({tag, ".icode"}, 64'(r.ic), 64'(e_ic));
    chk({tag, ".ifun"}, 64'(r.fn), 64'(e_fn));
    chk({tag, ".rA"}, 64'(r.ra), 64'(e_ra));
    chk({tag, ".rB"}, 64'(r.rb), 64'(e_rb));
    chk({tag, ".valC"}, r.c, e_c);
    chk({tag, ".valP"}, r.p, e_p);
    chk({tag, ".iv"}, 64'(r.iv), 64'(e_iv));
    chk({tag, ".err"}, 64'(r.err), 64'(e_err));
    chk({tag, ".hlt"}, 64'(r.h), 64'(e_h));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, ".pc"}, pc, 64'd0);
    chk({tag, ".valC"}, valC, 64'd0);
    chk({tag, ".valP"}, valP, 64'd0);
    chk({tag, ".icode"}, 64'(icode), 64'd0);
    chk({tag, ".rA"}, 64'(rA), 64'hF);
    chk({tag, ".rB"}, 64'(rB), 64'hF);
    chk({tag, ".hlt"}, 64'(hlt), 64'd0);
    chk({tag, ".iv"}, 64'(instr_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] mx;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; out_ready = 1'b1; hold_resp = 1'b0;
    pend = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    // irmovq $10,%rbx ; addq %rbx,%rdx ; nop ; halt
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
    mem[10] = 8'h60; mem[11] = 8'h32; mem[12] = 8'h10; mem[13] = 8'h00;

    step(3);
    chk_idle("reset");
    reset = 1'b0;
    step(1);
    chk("first_req", 64'(mem_req_valid), 64'd1);

    // Sequential fetch
    wait_recs("seq.count", 4, 100);
    chk_rec("seq0", 0, 64'd0,  4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd10, 1'b1, 1'b0, 1'b0);
    chk_rec("seq1", 1, 64'd10, 4'h6, 4'h0, 4'h3, 4'h2, 64'd0,  64'd12, 1'b1, 1'b0, 1'b0);
    chk_rec("seq2", 2, 64'd12, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,  64'd13, 1'b1, 1'b0, 1'b0);
    chk_rec("seq3", 3, 64'd13, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0,  64'd14, 1'b1, 1'b0, 1'b1);
    step(10);
    n = req_log.size();
    step(20);
    chk("seq.halt_noreq", 64'(req_log.size()), 64'(n));
    chk("seq.halt_outv", 64'(out_valid), 64'd0);

    // Unaligned redirect onto a call
    mem[13] = 8'h80; mem[14] = 8'h20;
    for (int i = 15; i < 22; i++) mem[i] = 8'h00;
    mem[22] = 8'h00; mem[32] = 8'h10; mem[33] = 8'h00;
    req_log.delete(); recs.delete();
    do_redirect(64'h0D);
`ifdef Y86_FETCH_PREDICT_EN
    wait_recs("call.count", 3, 100);
`else
    wait_recs("call.count", 2, 100);
`endif
    mx = (req_log.size() > 0) ? req_log[0] : 64'hDEAD;
    chk("call.first_addr", mx, 64'h08);
    chk_rec("call0", 0, 64'h0D, 4'h8, 4'h0, 4'hF, 4'hF, 64'h20, 64'h16, 1'b1, 1'b0, 1'b0);
`ifdef Y86_FETCH_PREDICT_EN
    chk_rec("call1", 1, 64'h20, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h21, 1'b1, 1'b0, 1'b0);
    chk_rec("call2", 2, 64'h21, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h22, 1'b1, 1'b0, 1'b1);
`else
    chk_rec("call1", 1, 64'h16, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h17, 1'b1, 1'b0, 1'b1);
`endif
    step(5);

    // Backpressure over a stream of nops
    for (int i = 256; i < 512; i++) mem[i] = 8'h10;
    out_ready = 1'b0;
    req_log.delete(); recs.delete();
    do_redirect(64'h100);
    step(12);
    for (int i = 0; i < 8; i++) begin
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.pc", pc, 64'h100);
      step(1);
    end
    chk("bp.reqs", 64'(req_log.size()), 64'd4);
    chk("bp.req_valid", 64'(mem_req_valid), 64'd0);
    out_ready = 1'b1;
    wait_recs("bp.count", 257, 700);
    for (int i = 0; i < 16; i++) begin
      rec_t r0, ri;
      r0 = '{default: '0}; ri = '{default: '0};
      if (recs.size() > 16) begin r0 = recs[0]; ri = recs[i]; end
      chk("bp.seq_pc", ri.pc, 64'h100 + 64'(i));
      chk("bp.rate", 64'(ri.cyc - r0.cyc), 64'(i));
    end
    chk_rec("bp.end", 256, 64'h200, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h201, 1'b1, 1'b0, 1'b1);
    step(5);

    // Redirect while a request is outstanding
    mem[768] = 8'h10;
    mem[64] = 8'h60; mem[65] = 8'h01; mem[66] = 8'h00;
    req_log.delete(); recs.delete();
    hold_resp = 1'b1;
    do_redirect(64'h300);
    step(3);
    chk("disc.req_count", 64'(req_log.size()), 64'd1);
    do_redirect(64'h40);
    step(2);
    hold_resp = 1'b0;
    wait_recs("disc.count", 2, 100);
    mx = (req_log.size() > 1) ? req_log[1] : 64'hDEAD;
    chk("disc.second_addr", mx, 64'h40);
    chk_rec("disc0", 0, 64'h40, 4'h6, 4'h0, 4'h0, 4'h1, 64'd0, 64'h42, 1'b1, 1'b0, 1'b0);
    chk_rec("disc1", 1, 64'h42, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h43, 1'b1, 1'b0, 1'b1);
    step(5);

    // Instruction running past the end of memory
    mem[1020] = 8'h30; mem[1021] = 8'hF3; mem[1022] = 8'h01; mem[1023] = 8'h00;
    req_log.delete(); recs.delete();
    do_redirect(64'd1020);
    wait_recs("bound.count", 1, 100);
    begin
      rec_t r;
      r = '{default: '0};
      if (recs.size() > 0) r = recs[0];
      chk("bound.pc", r.pc, 64'd1020);
      chk("bound.icode", 64'(r.ic), 64'h3);
      chk("bound.err", 64'(r.err), 64'd1);
      chk("bound.valP", r.p, 64'd1020);
    end
    step(20);
    chk("bound.outv", 64'(out_valid), 64'd0);
    chk("bound.req_valid", 64'(mem_req_valid), 64'd0);
    chk("bound.req_count", 64'(req_log.size()), 64'd1);
    mx = 64'd0;
    foreach (req_log[i]) if (req_log[i] > mx) mx = req_log[i];
    chk("bound.max_addr_ok", 64'(mx < 64'd1024), 64'd1);

    // Illegal opcode, then reset while a read is pending
    mem[0] = 8'hF0;
    req_log.delete(); recs.delete();
    do_redirect(64'd0);
    wait_recs("ill.count", 1, 100);
    chk_rec("ill0", 0, 64'd0, 4'hF, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b0, 1'b0);
    step(10);
    chk("ill.outv", 64'(out_valid), 64'd0);
    chk("ill.req_valid", 64'(mem_req_valid), 64'd0);
    req_log.delete();
    hold_resp = 1'b1;
    do_redirect(64'h40);
    step(2);
    chk("rst.pending", 64'(req_log.size()), 64'd1);
    reset = 1'b1;
    #1;
    chk_idle("rst.mid");
    hold_resp = 1'b0;
    step(2);
    req_log.delete(); recs.delete();
    reset = 1'b0;
    wait_recs("rst.count", 1, 50);
    mx = (req_log.size() > 0) ? req_log[0] : 64'hDEAD;
    chk("rst.first_addr", mx, 64'd0);
    chk_rec("rst0", 0, 64'd0, 4'hF, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
